bc_horner: RTL and testbench
============================

# bc_horner

Control block (BC) for the BO operational datapath: a Moore state machine that drives BO's register loads (LX, LH, LS), operator select (H) and mux selects (M0, M1, M2) to evaluate a polynomial in X by Horner's rule. It sits directly upstream of BO, and its outputs connect one-to-one to BO's control inputs. It handshakes with the host via start/busy/done; the host reads the result from BO's RESULT port.

## Interface
- No parameters (widths fixed by BO).
- clk  in  1  rising-edge clock, shared with BO
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request a computation; sampled only in IDLE
- mode  in  1  0: Y = A·X² + B·X + C; 1: Y = A·X + C; latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; BO RESULT valid from this cycle
- LX, LH, LS  out  1 each  BO register load enables
- H  out  1  BO operator: 0 = add, 1 = multiply
- M0  out  2  BO input select: 00 A, 01 B, 10 C
- M2  out  2  BO left operand: 00 LX reg, 01 M0 out, 10 LS reg, 11 LH reg
- M1  out  2  BO right operand: 00 M0 out, 01 LX reg, 10 LS reg, 11 LH reg

## Operation
- States: IDLE, LOAD_X, MUL_AX, ADD_B, MUL_X, ADD_C, DONE. Outputs are decoded from the state only (no input-to-output paths).
- In IDLE, all control outputs are 0, busy=0 and done=0. The next state is LOAD_X if start=1; at that edge mode is latched into mode_q.
- LOAD_X: LX=1 → BO loads X. Next state is MUL_AX.
- MUL_AX: M0=00, M2=00, M1=00, H=1, LH=1 → LH = X·A. Next state is ADD_C if mode_q=1, else ADD_B.
- ADD_B: M0=01, M2=11, M1=00, H=0, LH=1 → LH = LH + B. Next state is MUL_X.
- MUL_X: M2=11, M1=01, H=1, LH=1 → LH = LH·X. M0 is held at 00. Next state is ADD_C.
- ADD_C: M0=10, M2=11, M1=00, H=0, LS=1 → LS = LH + C. Next state is DONE.
- DONE: done=1, all loads 0. Next state is IDLE unconditionally.
- Only one load enable is asserted in any state.
- Unused selects are held at 00.
- start is ignored outside IDLE, including in DONE; a new run needs start high in IDLE.
- The host holds A, B, C and X stable from the accepting edge until done, because BO reads them combinationally.
- Arithmetic is BO's: 16-bit registers, results wrap modulo 2^16. bc_horner performs no width handling.
- Illegal or unreachable state encodings go to IDLE on the next edge.

## Timing
- Reset (rst=0) acts asynchronously: the state goes to IDLE, mode_q=0, and all outputs are 0 immediately. This holds mid-run; the partial LH/LS contents in BO are not cleared, and RESULT is undefined until the next done.
- Let edge 0 be the edge that samples start=1 in IDLE.
- mode 0: states LOAD_X through DONE occupy cycles 1 to 6. done is high in cycle 6, and IDLE is entered in cycle 7. Latency from start to done is 6 cycles.
- mode 1: LOAD_X, MUL_AX, ADD_C and DONE occupy cycles 1 to 4. done is high in cycle 4.
- busy rises in cycle 1 and falls when IDLE is re-entered.
- Back-to-back runs: start held high continuously gives one run every 7 cycles (mode 0) or every 5 cycles (mode 1).
- RESULT holds its value after done until the next ADD_C.

## Test plan
- Reset then idle: rst=0 → all outputs 0 and busy=0. Release rst with start=0 for 10 cycles → outputs stay 0.
- Quadratic: A=2, B=3, C=4, X=5, mode=0, one-cycle start → done at start+6 and RESULT=69. The control vector matches the table per state.
- Linear: same operands with mode=1 → done at start+4 and RESULT=14. ADD_B and MUL_X are never visited (H/LH trace checked).
- Wrap: A=B=C=X=255, mode=0 → RESULT=511 (mod 2^16).
- Ignored start: pulse start during MUL_X and during DONE → no restart, and a single done is observed. With start held high, runs repeat every 7 cycles.
- Mid-run reset: assert rst=0 in ADD_B → outputs are 0 asynchronously, before the next edge. After release, a fresh mode-0 run with A=1, B=0, C=0, X=3 gives RESULT=9.

Source files
------------

// File: rtl/bc_horner_if.sv
// Host/BO-facing bundle of bc_horner: start/busy/done handshake plus the
// control word that drives the BO datapath (loads, operator, mux selects).
interface bc_horner_if;
    logic       start;
    logic       mode;
    logic       busy;
    logic       done;
    logic       LX;
    logic       LH;
    logic       LS;
    logic       H;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;

    // Host side: issues requests and observes the control word.
    modport master (
        output start, mode,
        input  busy, done, LX, LH, LS, H, M0, M1, M2
    );

    // Controller side: bc_horner itself.
    modport slave (
        input  start, mode,
        output busy, done, LX, LH, LS, H, M0, M1, M2
    );
endinterface

// File: rtl/bc_horner.sv
// bc_horner: Moore controller sequencing the BO datapath through Horner's
// rule. mode 0 evaluates A*X^2 + B*X + C, mode 1 evaluates A*X + C.
//
//   state  | meaning
//   -------+---------------------------------------------
//   IDLE   | waiting for start, all controls low
//   LOAD_X | LX: BO captures X
//   MUL_AX | LH <= X * A
//   ADD_B  | LH <= LH + B            (quadratic only)
//   MUL_X  | LH <= LH * X            (quadratic only)
//   ADD_C  | LS <= LH + C
//   DONE   | one-cycle done pulse, RESULT valid
module bc_horner (
    input  logic        clk,
    input  logic        rst,
    bc_horner_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MUL_AX = 3'd2,
        ADD_B  = 3'd3,
        MUL_X  = 3'd4,
        ADD_C  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t state;
    state_t state_nx;
    logic   mode_q;

    // State register; mode is captured only on the edge that accepts start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                mode_q <= bus.mode;
            end
        end
    end

    // Next-state and state-decoded control word; nothing depends on inputs
    // except the IDLE transition and the mode branch after MUL_AX.
    always_comb begin
        state_nx = IDLE;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.LX   = 1'b0;
        bus.LH   = 1'b0;
        bus.LS   = 1'b0;
        bus.H    = 1'b0;
        bus.M0   = 2'b00;
        bus.M1   = 2'b00;
        bus.M2   = 2'b00;
        case (state)
            IDLE: begin
                state_nx = bus.start ? LOAD_X : IDLE;
            end
            LOAD_X: begin
                bus.busy = 1'b1;
                bus.LX   = 1'b1;
                state_nx = MUL_AX;
            end
            MUL_AX: begin
                bus.busy = 1'b1;
                bus.H    = 1'b1;
                bus.LH   = 1'b1;
                state_nx = mode_q ? ADD_C : ADD_B;
            end
            ADD_B: begin
                bus.busy = 1'b1;
                bus.M0   = 2'b01;
                bus.M2   = 2'b11;
                bus.LH   = 1'b1;
                state_nx = MUL_X;
            end
            MUL_X: begin
                bus.busy = 1'b1;
                bus.M2   = 2'b11;
                bus.M1   = 2'b01;
                bus.H    = 1'b1;
                bus.LH   = 1'b1;
                state_nx = ADD_C;
            end
            ADD_C: begin
                bus.busy = 1'b1;
                bus.M0   = 2'b10;
                bus.M2   = 2'b11;
                bus.LS   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bc_horner.sv
// Directed bench for bc_horner with a small behavioural BO datapath so the
// produced RESULT can be compared against hand-computed polynomial values.
module tb_bc_horner;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bc_horner_if bus ();

    bc_horner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Control word layout: busy done LX LH LS H M0[1:0] M2[1:0] M1[1:0]
    localparam logic [11:0] V_IDLE   = 12'b0_0_0_0_0_0_00_00_00;
    localparam logic [11:0] V_LOAD_X = 12'b1_0_1_0_0_0_00_00_00;
    localparam logic [11:0] V_MUL_AX = 12'b1_0_0_1_0_1_00_00_00;
    localparam logic [11:0] V_ADD_B  = 12'b1_0_0_1_0_0_01_11_00;
    localparam logic [11:0] V_MUL_X  = 12'b1_0_0_1_0_1_00_11_01;
    localparam logic [11:0] V_ADD_C  = 12'b1_0_0_0_1_0_10_11_00;
    localparam logic [11:0] V_DONE   = 12'b1_1_0_0_0_0_00_00_00;

    logic [11:0] ctl_obs;
    assign ctl_obs = {bus.busy, bus.done, bus.LX, bus.LH, bus.LS, bus.H,
                      bus.M0, bus.M2, bus.M1};

    // Behavioural BO: operand muxes, add/multiply, three 16-bit registers.
    logic [15:0] op_a = '0, op_b = '0, op_c = '0, op_x = '0;
    logic [15:0] reg_x = '0, reg_h = '0, reg_s = '0;
    logic [15:0] m0_out, left, right, alu;
    logic [31:0] prod;

    // BO combinational operand selection and operator.
    always_comb begin
        case (bus.M0)
            2'b00:   m0_out = op_a;
            2'b01:   m0_out = op_b;
            2'b10:   m0_out = op_c;
            default: m0_out = 16'h0;
        endcase
        case (bus.M2)
            2'b00:   left = reg_x;
            2'b01:   left = m0_out;
            2'b10:   left = reg_s;
            default: left = reg_h;
        endcase
        case (bus.M1)
            2'b00:   right = m0_out;
            2'b01:   right = reg_x;
            2'b10:   right = reg_s;
            default: right = reg_h;
        endcase
        prod = {16'h0, left} * {16'h0, right};
        alu  = bus.H ? prod[15:0] : (left + right);
    end

    // BO registers; not cleared by the controller reset.
    always @(posedge clk) begin
        if (bus.LX) reg_x <= op_x;
        if (bus.LH) reg_h <= alu;
        if (bus.LS) reg_s <= alu;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One run with a one-cycle start; checks the control word every cycle,
    // RESULT in the done cycle, the number of LH loads and the return to IDLE.
    task automatic run_seq(input logic m, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] x,
                           input logic [15:0] res, input string tag);
        logic [11:0] seq [6];
        int n;
        int lh_cnt;
        if (m) begin
            seq = '{V_LOAD_X, V_MUL_AX, V_ADD_C, V_DONE, V_IDLE, V_IDLE};
            n = 4;
        end else begin
            seq = '{V_LOAD_X, V_MUL_AX, V_ADD_B, V_MUL_X, V_ADD_C, V_DONE};
            n = 6;
        end
        op_a = a; op_b = b; op_c = c; op_x = x;
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = ~m;
        lh_cnt = 0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_ctl"}, 32'(ctl_obs), 32'(seq[i]));
            if (bus.LH) lh_cnt++;
            if (i == n - 1) check({tag, "_result"}, 32'(reg_s), 32'(res));
            tick();
        end
        check({tag, "_lh_loads"}, 32'(lh_cnt), m ? 32'd1 : 32'd3);
        check({tag, "_idle"}, 32'(ctl_obs), 32'(V_IDLE));
    endtask

    // start held high: done must appear at first_done, +period, +2*period.
    task automatic b2b(input logic m, input int first_done, input int period, input string tag);
        int d [3];
        int nd;
        nd = 0;
        d = '{0, 0, 0};
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 3 * period; cyc++) begin
            if (bus.done) begin
                if (nd < 3) d[nd] = cyc;
                nd++;
            end
            if (cyc == 3 * period) bus.start = 1'b0;
            else tick();
        end
        check({tag, "_ndone"}, 32'(nd), 32'd3);
        check({tag, "_done0"}, 32'(d[0]), 32'(first_done));
        check({tag, "_done1"}, 32'(d[1]), 32'(first_done + period));
        check({tag, "_done2"}, 32'(d[2]), 32'(first_done + 2 * period));
        tick();
        check({tag, "_stop"}, 32'(bus.busy), 32'd0);
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        int n_busy;
        bus.start = 1'b0;
        bus.mode  = 1'b0;

        #1 rst = 1'b0;
        #1 check("reset_ctl", 32'(ctl_obs), 32'(V_IDLE));
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ctl", 32'(ctl_obs), 32'(V_IDLE));
        end

        run_seq(1'b0, 16'd2, 16'd3, 16'd4, 16'd5, 16'd69, "quad");
        run_seq(1'b1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd14, "lin");
        run_seq(1'b0, 16'd255, 16'd255, 16'd255, 16'd255, 16'd511, "wrap");

        // start pulsed in MUL_X and DONE must not restart the machine
        op_a = 16'd2; op_b = 16'd3; op_c = 16'd4; op_x = 16'd5;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("ign_mul_x", 32'(ctl_obs), 32'(V_MUL_X));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign_add_c", 32'(ctl_obs), 32'(V_ADD_C));
        tick();
        check("ign_done", 32'(ctl_obs), 32'(V_DONE));
        check("ign_result", 32'(reg_s), 32'd69);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign_idle", 32'(ctl_obs), 32'(V_IDLE));
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.busy || bus.done) n_busy++;
        end
        check("ign_no_restart", 32'(n_busy), 32'd0);
        check("ign_result_hold", 32'(reg_s), 32'd69);

        b2b(1'b0, 6, 7, "b2b_quad");
        b2b(1'b1, 4, 5, "b2b_lin");

        // asynchronous reset in ADD_B, observed before the next clock edge
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("mid_add_b", 32'(ctl_obs), 32'(V_ADD_B));
        #2 rst = 1'b0;
        #1 check("mid_async_rst", 32'(ctl_obs), 32'(V_IDLE));
        @(negedge clk) rst = 1'b1;
        tick();
        check("mid_after_rel", 32'(ctl_obs), 32'(V_IDLE));
        run_seq(1'b0, 16'd1, 16'd0, 16'd0, 16'd3, 16'd9, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
